// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives the ROM and
// buffers fetched words in a small prefetch queue towards ID.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  input  logic        halt_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [31:0]   pc;
  logic [31:0]   q_pc   [QDEPTH];
  logic [31:0]   q_inst [QDEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;

  logic pop;
  logic push_ok;
  logic unused_lsb;

  assign unused_lsb = ^new_pc_i[1:0];

  always_comb begin
    state_nx = state;
    unique case (state)
      S_BOOT:  state_nx = S_RUN;
      S_RUN:   if (halt_i) state_nx = S_HALT;
      S_HALT:  if (!halt_i) state_nx = S_RUN;
      default: state_nx = S_BOOT;
    endcase
  end

  // Outputs are gated by rst so nothing handshakes during reset.
  always_comb begin
    id_valid_o = rst & (count != '0);
    id_pc_o    = '0;
    id_inst_o  = '0;
    if (id_valid_o) begin
      id_pc_o   = q_pc[head];
      id_inst_o = q_inst[head];
    end
    pop        = id_valid_o & id_ready_i;
    push_ok    = (count < QFULL) | pop;
    rom_ce_o   = rst & (state == S_RUN) & ~halt_i
               & ~flush_i & push_ok;
    rom_addr_o = pc;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_BOOT;
      pc    <= {RESET_PC[31:2], 2'b00};
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      if (flush_i) begin
        pc    <= {new_pc_i[31:2], 2'b00};
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (rom_ce_o) begin
          pc   <= pc + 32'd4;
          tail <= tail + 1'b1;
        end
        if (pop) head <= head + 1'b1;
        count <= count + CW'(rom_ce_o) - CW'(pop);
      end
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (rom_ce_o) begin
      q_pc[tail]   <= pc;
      q_inst[tail] <= rom_inst_i;
    end
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Instruction-fetch controller that sequences the single-port, combinational-read instruction ROM.
- Owns the PC and drives ROM chip-enable and address.
- Captures each returned word with its PC into a small prefetch queue and presents {pc, inst} to the ID stage over a valid/ready handshake.
- Sits between the PC/branch logic and the ROM; redirects arrive from ID/EX via flush.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset; bits [1:0] forced to 0.
- QDEPTH, 2: prefetch queue entries; power of two, minimum 2.

Ports:
- clk  in  1: rising-edge clock.
- rst  in  1: synchronous, active-low reset.
- flush_i  in  1: redirect; discard the queue and restart at new_pc_i.
- new_pc_i  in  32: redirect target; bits [1:0] ignored and treated as 0.
- halt_i  in  1: suspend new fetches; the queue still drains.
- rom_ce_o  out  1: ROM chip enable.
- rom_addr_o  out  32: ROM byte address (word-aligned).
- rom_inst_i  in  32: ROM data; valid in the same cycle as ce/addr.
- id_valid_o  out  1: head entry valid.
- id_ready_i  in  1: ID accepts the head entry this cycle.
- id_pc_o  out  32: PC of the head entry.
- id_inst_o  out  32: instruction of the head entry.

Behaviour:
- Reset: rst==0 sampled at posedge has priority over every other input.
  - pc <= RESET_PC; queue emptied; state <= S_BOOT.
  - While in reset and in the cycle after: rom_ce_o=0, rom_addr_o=pc, id_valid_o=0, id_pc_o=0, id_inst_o=0.
- States:
  - S_BOOT: always -> S_RUN (one idle cycle, ce=0).
  - S_RUN: halt_i=1 -> S_HALT.
  - S_HALT: halt_i=0 -> S_RUN.
  - flush_i does not change state, except that flush in S_BOOT still goes to S_RUN.
- pop = id_valid_o & id_ready_i.
- push_ok = (count<QDEPTH) | pop.
- rom_ce_o = (state==S_RUN) & !halt_i & !flush_i & push_ok. Combinational from registers and inputs.
- rom_addr_o = pc at all times.
- Fetch: when rom_ce_o=1 at posedge:
  - {pc, rom_inst_i} is written at the queue tail.
  - pc <= pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
- Latency: word at address A is fetched in cycle N and appears on id_* in cycle N+1. Sustained throughput is 1 instruction/cycle while ID is ready.
- Queue: FIFO with head/tail pointers and a count of width log2(QDEPTH)+1.
  - Outputs id_* come directly from the head entry.
  - Push and pop in the same cycle with count==QDEPTH is legal; count stays unchanged.
  - Push and pop in the same cycle with count==1 is legal; the head advances to the new entry.
- Empty: id_valid_o=0; id_pc_o and id_inst_o read 0.
- Full with no pop: ce=0; pc holds; entries hold.
- Held entry: while id_valid_o=1 and id_ready_i=0, id_pc_o and id_inst_o must not change.
- Flush (flush_i=1 at posedge, rst=1):
  - Queue emptied and pc <= {new_pc_i[31:2],2'b00}.
  - The same-cycle pop is discarded; no push that cycle.
  - The next cycle fetches new_pc if not halted, with id_valid_o=0.
  - Flush also takes effect while halted and in S_BOOT.
- Halt: asserting halt_i blocks the fetch in that same cycle; pc freezes. Deasserting resumes fetch the cycle after the state returns to S_RUN, i.e. one bubble.
- Reset mid-operation: queue contents are lost and there is no ID handshake completion in that cycle.

Test Plan:
1. Reset then run, RESET_PC=0, ROM word i = 32'h1000_0000+i, id_ready_i=1 -> cycle 1 after reset ce=0; from cycle 2 ce=1 with addr 0,4,8,…; id_* shows pc 0/inst 1000_0000 in cycle 3, then one per cycle.
2. Backpressure: id_ready_i=0 from the first valid -> queue fills to 2 (pc 0,4); ce drops with addr=8; id_* holds pc 0 stable. Raising ready -> pc 0, 4, 8 delivered on consecutive cycles with no bubble.
3. Flush with queue holding pc 8 and C, flush_i=1, new_pc_i=32'h0000_0043 -> next cycle id_valid_o=0, addr=32'h40, ce=1; the following cycle id_pc_o=32'h40; pcs 8 and C are never accepted.
4. Halt: halt_i=1 for 3 cycles at pc=32'h20 -> ce=0; addr stays 32'h20; queue drains to empty. Release -> one bubble cycle, then fetch of 32'h20.
5. Wrap: flush to 32'hFFFF_FFF8 -> delivered pcs FFFF_FFF8, FFFF_FFFC, 0000_0000.
6. Simultaneous events: rst=0 together with flush_i=1 -> pc=RESET_PC and queue empty. flush_i=1 together with pop of a full queue -> queue empty and no push that cycle.
